// File: rtl/bellek_yanitlayici.sv
// bellek_yanitlayici: request/response data-memory model with byte-masked writes
// and a programmable read latency, returning read data over a valid/ready handshake.
module bellek_yanitlayici #(
   parameter int VERI_BIT  = 32,
   parameter int ADRES_BIT = 32,
   parameter int DERINLIK  = 1024,
   parameter int GECIKME   = 2
) (
   input  logic                  clk_i,
   input  logic                  rstn_i,
   input  logic [ADRES_BIT-1:0]  port_istek_adres_i,
   input  logic                  port_istek_gecerli_i,
   input  logic                  port_istek_yaz_i,
   input  logic [VERI_BIT-1:0]   port_istek_veri_i,
   input  logic [VERI_BIT/8-1:0] port_istek_maske_i,
   output logic                  port_istek_hazir_o,
   output logic [VERI_BIT-1:0]   port_veri_o,
   output logic                  port_veri_gecerli_o,
   input  logic                  port_veri_hazir_i,
   output logic                  adres_hata_o
);
   localparam int VERI_BYTE = VERI_BIT / 8;
   localparam int IDX_BIT   = $clog2(DERINLIK);

   typedef enum logic [1:0] {BOSTA, BEKLE, YANIT} durum_t;

   durum_t               r_durum;
   logic [3:0]           r_sayac;
   logic                 r_hazir;
   logic                 r_gecerli;
   logic [VERI_BIT-1:0]  r_veri;
   logic                 r_hata;
   logic [IDX_BIT-1:0]   r_idx;
   logic                 r_disi;
   logic [VERI_BIT-1:0]  r_mem [DERINLIK];

   logic [IDX_BIT-1:0]   w_idx;
   logic                 w_disi;
   logic                 w_kabul;
   logic [VERI_BIT-1:0]  w_yeni;
   logic                 w_unused;

   assign w_idx    = port_istek_adres_i[IDX_BIT+1:2];
   assign w_disi   = |port_istek_adres_i[ADRES_BIT-1:IDX_BIT+2];
   assign w_kabul  = port_istek_gecerli_i && r_hazir;
   assign w_unused = ^port_istek_adres_i[1:0];

   always_comb begin
      w_yeni = r_mem[w_idx];
      for (int b = 0; b < VERI_BYTE; b++)
         if (port_istek_maske_i[b]) w_yeni[b*8 +: 8] = port_istek_veri_i[b*8 +: 8];
   end

   // Array is deliberately not reset; a write lands at its accept edge.
   always_ff @(posedge clk_i)
      if (rstn_i && w_kabul && port_istek_yaz_i && !w_disi) r_mem[w_idx] <= w_yeni;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_durum   <= BOSTA;
         r_sayac   <= '0;
         r_hazir   <= 1'b1;
         r_gecerli <= 1'b0;
         r_veri    <= '0;
         r_hata    <= 1'b0;
         r_idx     <= '0;
         r_disi    <= 1'b0;
      end else begin
         r_hata <= w_kabul && w_disi;
         case (r_durum)
            BOSTA: if (w_kabul && !port_istek_yaz_i) begin
               r_idx   <= w_idx;
               r_disi  <= w_disi;
               r_sayac <= 4'(GECIKME);
               r_hazir <= 1'b0;
               if (GECIKME == 0) begin
                  r_durum   <= YANIT;
                  r_gecerli <= 1'b1;
                  r_veri    <= w_disi ? '0 : r_mem[w_idx];
               end else begin
                  r_durum <= BEKLE;
               end
            end
            BEKLE: begin
               r_sayac <= r_sayac - 4'd1;
               if (r_sayac == 4'd1) begin
                  r_durum   <= YANIT;
                  r_gecerli <= 1'b1;
                  r_veri    <= r_disi ? '0 : r_mem[r_idx];
               end
            end
            YANIT: if (port_veri_hazir_i) begin
               r_durum   <= BOSTA;
               r_gecerli <= 1'b0;
               r_veri    <= '0;
               r_hazir   <= 1'b1;
            end
            default: r_durum <= BOSTA;
         endcase
      end
   end

   assign port_istek_hazir_o  = r_hazir;
   assign port_veri_gecerli_o = r_gecerli;
   assign port_veri_o         = r_veri;
   assign adres_hata_o        = r_hata;
endmodule

// File: tb/tb_bellek_yanitlayici.sv
// tb_bellek_yanitlayici: randomized and directed checks of bellek_yanitlayici against
// a word-array reference model; a second instance covers zero read latency.
module tb_bellek_yanitlayici;
   localparam int G = 2;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [31:0] adres = '0, wdata = '0, z_adres = '0, z_wdata = '0;
   logic        gec = 1'b0, yaz = 1'b0, vh = 1'b1;
   logic        z_gec = 1'b0, z_yaz = 1'b0, z_vh = 1'b1;
   logic [3:0]  maske = '0, z_maske = '0;
   logic        hazir, vgec, hata, z_hazir, z_vgec, z_hata;
   logic [31:0] veri, z_veri;
   int          total = 0, bad = 0;
   logic [31:0] mdl [1024];

   always #5 clk = ~clk;

   bellek_yanitlayici #(.GECIKME(G)) dut (
      .clk_i(clk), .rstn_i(rstn),
      .port_istek_adres_i(adres), .port_istek_gecerli_i(gec), .port_istek_yaz_i(yaz),
      .port_istek_veri_i(wdata), .port_istek_maske_i(maske), .port_istek_hazir_o(hazir),
      .port_veri_o(veri), .port_veri_gecerli_o(vgec), .port_veri_hazir_i(vh),
      .adres_hata_o(hata));

   bellek_yanitlayici #(.GECIKME(0)) dut0 (
      .clk_i(clk), .rstn_i(rstn),
      .port_istek_adres_i(z_adres), .port_istek_gecerli_i(z_gec), .port_istek_yaz_i(z_yaz),
      .port_istek_veri_i(z_wdata), .port_istek_maske_i(z_maske), .port_istek_hazir_o(z_hazir),
      .port_veri_o(z_veri), .port_veri_gecerli_o(z_vgec), .port_veri_hazir_i(z_vh),
      .adres_hata_o(z_hata));

   function automatic bit disi(input logic [31:0] a);
      return a >= 32'd4096;
   endfunction

   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
      total++;
      if (hazir !== 1'b1) begin bad++; $display("FAIL wr_hazir a=%h got=%b exp=1", a, hazir); end
      adres = a; wdata = d; maske = m; yaz = 1'b1; gec = 1'b1;
      @(posedge clk); #1;
      gec = 1'b0; yaz = 1'b0;
      if (!disi(a))
         for (int b = 0; b < 4; b++)
            if (m[b]) mdl[a / 4][b*8 +: 8] = d[b*8 +: 8];
      total++;
      if (hata !== disi(a)) begin bad++; $display("FAIL wr_hata a=%h got=%b exp=%b", a, hata, disi(a)); end
   endtask

   task automatic do_read(input logic [31:0] a, input int hold);
      logic [31:0] exp;
      int n;
      exp = disi(a) ? 32'h0 : mdl[a / 4];
      vh = (hold == 0); adres = a; yaz = 1'b0; gec = 1'b1;
      @(posedge clk); #1;
      gec = 1'b0; n = 1;
      total++;
      if ({hata, hazir} !== {disi(a), 1'b0}) begin
         bad++; $display("FAIL rd_accept a=%h got hata/hazir=%b%b exp=%b0", a, hata, hazir, disi(a));
      end
      while (vgec !== 1'b1 && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      total++;
      if (n != G + 1) begin bad++; $display("FAIL rd_latency a=%h got=%0d exp=%0d", a, n, G + 1); end
      total++;
      if (veri !== exp) begin bad++; $display("FAIL rd_data a=%h got=%h exp=%h", a, veri, exp); end
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         total++;
         if ({vgec, hazir, veri} !== {1'b1, 1'b0, exp}) begin
            bad++; $display("FAIL rd_hold a=%h cyc=%0d got v=%b h=%b d=%h exp d=%h", a, i, vgec, hazir, veri, exp);
         end
      end
      vh = 1'b1;
      @(posedge clk); #1;
      total++;
      if ({vgec, hazir, veri} !== {1'b1 ^ 1'b1, 1'b1, 32'h0}) begin
         bad++; $display("FAIL rd_done a=%h got v=%b h=%b d=%h exp v=0 h=1 d=0", a, vgec, hazir, veri);
      end
   endtask

   task automatic test_reset;
      total++;
      if ({hazir, vgec, veri, hata, z_hazir, z_vgec, z_veri, z_hata} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0}) begin
         bad++; $display("FAIL reset_state got h=%b v=%b d=%h e=%b z: h=%b v=%b d=%h e=%b", hazir, vgec, veri, hata, z_hazir, z_vgec, z_veri, z_hata);
      end
      @(posedge clk); #1;
      rstn = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_full_write;
      do_write(32'h10, 32'hDEADBEEF, 4'hF);
      do_read(32'h10, 0);
   endtask

   task automatic test_mask;
      do_write(32'h20, 32'h11223344, 4'hF);
      do_write(32'h20, 32'hAABBCCDD, 4'b0101);
      total++;
      if (mdl[8] !== 32'h11BB33DD) begin bad++; $display("FAIL mask_model got=%h exp=11bb33dd", mdl[8]); end
      do_read(32'h20, 0);
   endtask

   task automatic test_back_to_back;
      for (int i = 0; i < 4; i++) do_write(32'(i * 4), $urandom, 4'hF);
      for (int i = 0; i < 4; i++) do_read(32'(i * 4), 0);
   endtask

   task automatic test_backpressure;
      do_read(32'h10, 5);
   endtask

   task automatic test_out_of_range;
      do_read(32'h0010_0000, 0);
      do_write(32'h0010_0000, 32'h5A5A5A5A, 4'hF);
      do_read(32'h0, 0);
      do_read(32'h10, 0);
   endtask

   task automatic test_reset_mid_read;
      adres = 32'h10; yaz = 1'b0; gec = 1'b1; vh = 1'b1;
      @(posedge clk); #1;
      gec = 1'b0;
      #2 rstn = 1'b0;
      #1;
      total++;
      if ({hazir, vgec, veri, hata} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
         bad++; $display("FAIL async_reset got h=%b v=%b d=%h e=%b exp h=1 v=0 d=0 e=0", hazir, vgec, veri, hata);
      end
      @(posedge clk); #1;
      rstn = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         total++;
         if ({vgec, hazir} !== 2'b01) begin bad++; $display("FAIL post_reset cyc=%0d got v=%b h=%b exp v=0 h=1", i, vgec, hazir); end
      end
   endtask

   task automatic test_gecikme0;
      logic [31:0] d;
      d = $urandom;
      z_adres = 32'h40; z_wdata = d; z_maske = 4'hF; z_yaz = 1'b1; z_gec = 1'b1;
      @(posedge clk); #1;
      z_yaz = 1'b0;
      @(posedge clk); #1;
      z_gec = 1'b0;
      total++;
      if ({z_vgec, z_hazir, z_veri} !== {1'b1, 1'b0, d}) begin
         bad++; $display("FAIL g0_data got v=%b h=%b d=%h exp v=1 h=0 d=%h", z_vgec, z_hazir, z_veri, d);
      end
      @(posedge clk); #1;
      total++;
      if ({z_vgec, z_hazir, z_veri} !== {1'b0, 1'b1, 32'h0}) begin
         bad++; $display("FAIL g0_done got v=%b h=%b d=%h exp v=0 h=1 d=0", z_vgec, z_hazir, z_veri);
      end
   endtask

   task automatic test_random;
      logic [31:0] a;
      int r;
      for (int i = 0; i < 16; i++) do_write(32'(i * 4), $urandom, 4'hF);
      for (int k = 0; k < 60; k++) begin
         r = $urandom_range(0, 9);
         a = {26'(0), 4'($urandom_range(0, 15)), 2'($urandom)};
         if (r == 9) a = 32'($urandom) | 32'h1000;
         if (r < 4 || (r == 9 && k[0])) do_write(a, $urandom, 4'($urandom));
         else do_read(a, $urandom_range(0, 3));
      end
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      test_reset;
      test_full_write;
      test_mask;
      test_back_to_back;
      test_backpressure;
      test_out_of_range;
      test_reset_mid_read;
      test_gecikme0;
      test_random;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
